// File: rtl/i2c_target_regport_if.sv
// i2c_target_regport_if: I2C bus lines plus parallel register port
// of the I2C register-port target.
interface i2c_target_regport_if #(
  parameter int PTR_W = 8
);

  logic             scl_in;
  logic             sda_in;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic [7:0]       reg_rdata;
  logic             busy;

  modport master (
    output scl_in,
    output sda_in,
    output reg_rdata,
    input  sda_oe,
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  busy
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    input  reg_rdata,
    output sda_oe,
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output busy
  );

endinterface

// File: rtl/i2c_target_regport.sv
// i2c_target_regport: oversampled I2C target bridging bus reads/writes
// to a parallel register port with an auto-incrementing pointer.
module i2c_target_regport #(
  parameter logic [6:0] DEV_ADDR = 7'd49,
  parameter int         PTR_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  i2c_target_regport_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    MACK,
    IGNORE
  } state_t;

  state_t     state;
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic       rw;
  logic       ack_hi;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_c;
  logic       stop_c;
  logic       last;
  logic [2:0] nxt_bit;
  logic [7:0] byte_in;

  // [1] is the synchronized level, [2] the previous one
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_c   = scl_q[1] & ~sda_q[2] & sda_q[1];
  assign last     = (bit_cnt == 3'd0);
  assign nxt_bit  = bit_cnt - 3'd1;
  assign byte_in  = {sh[6:0], sda_q[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      scl_q         <= 3'b111;
      sda_q         <= 3'b111;
      bit_cnt       <= 3'd7;
      sh            <= 8'h00;
      rw            <= 1'b0;
      ack_hi        <= 1'b0;
      bus.sda_oe    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= 8'h00;
      bus.reg_we    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], bus.scl_in};
      sda_q      <= {sda_q[1:0], bus.sda_in};
      bus.reg_we <= 1'b0;
      if (bus.reg_we)
        bus.reg_addr <= bus.reg_addr + PTR_W'(1);

      if (start_c) begin
        state      <= ADDR;
        bit_cnt    <= 3'd7;
        ack_hi     <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (stop_c) begin
        state      <= IDLE;
        bit_cnt    <= 3'd7;
        ack_hi     <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: bus.sda_oe <= 1'b0;

          ADDR: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= nxt_bit;
            if (last) begin
              bit_cnt <= 3'd7;
              if (byte_in[7:1] == DEV_ADDR) begin
                state <= ADDR_ACK;
                rw    <= byte_in[0];
              end else begin
                state <= IGNORE;
              end
            end
          end

          PTR: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= nxt_bit;
            if (last) begin
              bit_cnt      <= 3'd7;
              bus.reg_addr <= PTR_W'(byte_in);
              state        <= PTR_ACK;
            end
          end

          WDATA: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= nxt_bit;
            if (last) begin
              bit_cnt       <= 3'd7;
              bus.reg_wdata <= byte_in;
              bus.reg_we    <= 1'b1;
              state         <= WDATA_ACK;
            end
          end

          // first fall opens the ACK slot, second fall closes it
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_hi) begin
              ack_hi     <= 1'b1;
              bus.sda_oe <= 1'b1;
              bus.busy   <= 1'b1;
            end else begin
              ack_hi     <= 1'b0;
              bus.sda_oe <= 1'b0;
              if (state == ADDR_ACK && rw) begin
                sh           <= bus.reg_rdata;
                bus.sda_oe   <= ~bus.reg_rdata[7];
                bus.reg_addr <= bus.reg_addr + PTR_W'(1);
                bit_cnt      <= 3'd7;
                state        <= RDATA;
              end else if (state == ADDR_ACK) begin
                state <= PTR;
              end else begin
                state <= WDATA;
              end
            end
          end

          RDATA: if (scl_fall) begin
            if (last) begin
              bus.sda_oe <= 1'b0;
              bit_cnt    <= 3'd7;
              state      <= MACK;
            end else begin
              bus.sda_oe <= ~sh[nxt_bit];
              bit_cnt    <= nxt_bit;
            end
          end

          MACK: begin
            if (scl_rise && sda_q[1]) begin
              state <= IGNORE;
            end else if (scl_fall) begin
              sh           <= bus.reg_rdata;
              bus.sda_oe   <= ~bus.reg_rdata[7];
              bus.reg_addr <= bus.reg_addr + PTR_W'(1);
              bit_cnt      <= 3'd7;
              state        <= RDATA;
            end
          end

          IGNORE: bus.sda_oe <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
